// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 datapath: control word bit positions,
// the idle control word, the instruction opcodes and a bus helper.
package sap1_pkg;

    localparam int CON_CP   = 11;
    localparam int CON_EP   = 10;
    localparam int CON_LM_N = 9;
    localparam int CON_CE_N = 8;
    localparam int CON_LI_N = 7;
    localparam int CON_EI_N = 6;
    localparam int CON_LA_N = 5;
    localparam int CON_EA   = 4;
    localparam int CON_SU   = 3;
    localparam int CON_EU   = 2;
    localparam int CON_LB_N = 1;
    localparam int CON_LO_N = 0;

    // Control word that drives nothing and loads nothing
    localparam logic [11:0] CON_IDLE = 12'h3E3;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // True when more than one of the bus enables is active at once
    function automatic logic multi_driver(input logic [4:0] en);
        return (en & (en - 5'd1)) != 5'd0;
    endfunction

endpackage

// File: rtl/sap1_ram.sv
// Program/data memory for the SAP-1: combinational read at the MAR address,
// synchronous write from the programming port only. Never cleared by reset.
module sap1_ram
    import sap1_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Programming-port write; independent of reset so a write in a reset cycle lands
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: executes the 12-bit control word on the shared W-bus.
// Holds PC, MAR, IR, A, B, output register, the ALU and the bus mux, plus
// a RAM programming port, a sticky halt and a sticky bus-contention flag.
module sap1_datapath
    import sap1_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [11:0]              con,
    output logic [DATA_W-ADDR_W-1:0] opcode,
    input  logic                     prog_en,
    input  logic                     prog_we,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    output logic [DATA_W-1:0]        out_reg,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        pc,
    output logic [DATA_W-1:0]        bus,
    output logic                     carry,
    output logic                     halt,
    output logic                     bus_err
);

    localparam int OP_W = DATA_W - ADDR_W;

    logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;

    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] b_operand;
    logic [DATA_W:0]   alu_sum;
    logic [4:0]        drv_en;
    logic              load_en;

    assign cp   = con[CON_CP];
    assign ep   = con[CON_EP];
    assign lm_n = con[CON_LM_N];
    assign ce_n = con[CON_CE_N];
    assign li_n = con[CON_LI_N];
    assign ei_n = con[CON_EI_N];
    assign la_n = con[CON_LA_N];
    assign ea   = con[CON_EA];
    assign su   = con[CON_SU];
    assign eu   = con[CON_EU];
    assign lb_n = con[CON_LB_N];
    assign lo_n = con[CON_LO_N];

    assign opcode  = ir[DATA_W-1:ADDR_W];
    assign load_en = !prog_en && !halt;
    assign drv_en  = {ep, !ce_n, !ei_n, ea, eu};

    sap1_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clock (clock),
        .we    (prog_en && prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (mar),
        .rdata (ram_rdata)
    );

    // ALU: add, or subtract as A + ~B + 1 so the top bit is the no-borrow flag
    always_comb begin
        b_operand = su ? ~b_reg : b_reg;
        alu_sum   = {1'b0, a_reg} + {1'b0, b_operand} + {{DATA_W{1'b0}}, su};
    end

    // W-bus: OR of every enabled driver, zero when nobody drives
    always_comb begin
        bus = '0;
        if (ep) begin
            bus = bus | {{OP_W{1'b0}}, pc};
        end
        if (!ce_n) begin
            bus = bus | ram_rdata;
        end
        if (!ei_n) begin
            bus = bus | {{OP_W{1'b0}}, ir[ADDR_W-1:0]};
        end
        if (ea) begin
            bus = bus | a_reg;
        end
        if (eu) begin
            bus = bus | alu_sum[DATA_W-1:0];
        end
    end

    // Register file: reset, sticky flags, then control-word loads from pre-edge bus values
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            out_reg   <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
            halt      <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (multi_driver(drv_en)) begin
                bus_err <= 1'b1;
            end
            if (!prog_en && opcode == OP_W'(OP_HLT)) begin
                halt <= 1'b1;
            end
            if (load_en) begin
                if (cp) begin
                    pc <= pc + ADDR_W'(1);
                end
                if (!lm_n) begin
                    mar <= bus[ADDR_W-1:0];
                end
                if (!li_n) begin
                    ir <= bus;
                end
                if (!la_n) begin
                    a_reg <= bus;
                    if (eu) begin
                        carry <= alu_sum[DATA_W];
                    end
                end
                if (!lb_n) begin
                    b_reg <= bus;
                end
                if (!lo_n) begin
                    out_reg   <= bus;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sap1_datapath.sv
// Testbench for sap1_datapath: acts as the control unit, drives directed
// scenarios and random SAP-1 programs, and compares against an
// instruction-level model of the program's arithmetic.
module tb_sap1_datapath;
    import sap1_pkg::*;

    localparam logic [11:0] C_IDLE     = 12'h3E3;
    localparam logic [11:0] C_MAR_PC   = 12'h5E3;
    localparam logic [11:0] C_INC      = 12'hBE3;
    localparam logic [11:0] C_FETCH    = 12'h263;
    localparam logic [11:0] C_MAR_IR   = 12'h1A3;
    localparam logic [11:0] C_LOAD_A   = 12'h2C3;
    localparam logic [11:0] C_LOAD_B   = 12'h2E1;
    localparam logic [11:0] C_ADD      = 12'h3C7;
    localparam logic [11:0] C_SUB      = 12'h3CF;
    localparam logic [11:0] C_OUT      = 12'h3F2;
    localparam logic [11:0] C_SHOW_A   = 12'h3F3;
    localparam logic [11:0] C_RAM_RD   = 12'h2E3;
    localparam logic [11:0] C_SHOW_ALU = 12'h3E7;
    localparam logic [11:0] C_CONTEND  = 12'h7F3;
    localparam logic [11:0] C_INC_LDA  = 12'hBC3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] con = C_IDLE;
    logic        prog_en = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = 4'h0;
    logic [7:0]  prog_data = 8'h00;
    logic [3:0]  opcode;
    logic [7:0]  out_reg;
    logic        out_valid;
    logic [3:0]  pc;
    logic [7:0]  bus;
    logic        carry;
    logic        halt;
    logic        bus_err;

    int total = 0;
    int bad = 0;
    logic [7:0] outs_seen[$];

    sap1_datapath dut (
        .clock     (clock),
        .reset     (reset),
        .con       (con),
        .opcode    (opcode),
        .prog_en   (prog_en),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_reg   (out_reg),
        .out_valid (out_valid),
        .pc        (pc),
        .bus       (bus),
        .carry     (carry),
        .halt      (halt),
        .bus_err   (bus_err)
    );

    always #5 clock = ~clock;

    // One clock: control word changes on negedge, outputs sampled 1ns after posedge
    task automatic step(input logic [11:0] c);
        @(negedge clock);
        con = c;
        @(posedge clock);
        #1;
        if (out_valid === 1'b1) outs_seen.push_back(out_reg);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(C_IDLE);
        reset = 1'b1;
        outs_seen.delete();
    endtask

    task automatic prog_write(input logic [3:0] addr, input logic [7:0] data);
        prog_en = 1'b1;
        prog_we = 1'b1;
        prog_addr = addr;
        prog_data = data;
        step(C_IDLE);
        prog_we = 1'b0;
        prog_en = 1'b0;
    endtask

    task automatic read_a(output logic [7:0] v);
        step(C_SHOW_A);
        v = bus;
    endtask

    // Fetch one instruction and run its execute states as the control unit would
    task automatic run_instr(input logic [3:0] op, output logic [3:0] fetched);
        step(C_MAR_PC);
        step(C_INC);
        step(C_FETCH);
        fetched = opcode;
        case (op)
            OP_LDA: begin step(C_MAR_IR); step(C_LOAD_A); step(C_IDLE); end
            OP_ADD: begin step(C_MAR_IR); step(C_LOAD_B); step(C_ADD); end
            OP_SUB: begin step(C_MAR_IR); step(C_LOAD_B); step(C_SUB); end
            OP_OUT: begin step(C_OUT); step(C_IDLE); step(C_IDLE); end
            default: begin step(C_IDLE); step(C_IDLE); step(C_IDLE); end
        endcase
    endtask

    task automatic test_reset();
        logic [7:0] av;
        do_reset();
        total++; if (pc !== 4'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h expected 0", pc); end
        total++; if (out_reg !== 8'h00) begin bad++; $display("[TB] FAIL reset_out: got %h expected 00", out_reg); end
        total++; if (halt !== 1'b0) begin bad++; $display("[TB] FAIL reset_halt: got %b expected 0", halt); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_bus_err: got %b expected 0", bus_err); end
        total++; if (opcode !== 4'h0) begin bad++; $display("[TB] FAIL reset_opcode: got %h expected 0", opcode); end
        total++; if (carry !== 1'b0) begin bad++; $display("[TB] FAIL reset_carry: got %b expected 0", carry); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (bus !== 8'h00) begin bad++; $display("[TB] FAIL reset_idle_bus: got %h expected 00", bus); end
        read_a(av);
        total++; if (av !== 8'h00) begin bad++; $display("[TB] FAIL reset_a: got %h expected 00", av); end
    endtask

    task automatic test_program();
        logic [3:0] f;
        logic [7:0] av;
        prog_write(4'h0, 8'h09); prog_write(4'h1, 8'h1A); prog_write(4'h2, 8'h2B);
        prog_write(4'h3, 8'hE0); prog_write(4'h4, 8'hF0); prog_write(4'h9, 8'h10);
        prog_write(4'hA, 8'h14); prog_write(4'hB, 8'h18);
        do_reset();
        run_instr(OP_LDA, f);
        run_instr(OP_ADD, f);
        run_instr(OP_SUB, f);
        run_instr(OP_OUT, f);
        run_instr(OP_HLT, f);
        total++; if (outs_seen.size() != 1) begin bad++; $display("[TB] FAIL prog_out_pulses: got %0d expected 1", outs_seen.size()); end
        else begin
            total++; if (outs_seen[0] !== 8'h0C) begin bad++; $display("[TB] FAIL prog_out_value: got %h expected 0c", outs_seen[0]); end
        end
        total++; if (out_reg !== 8'h0C) begin bad++; $display("[TB] FAIL prog_out_reg: got %h expected 0c", out_reg); end
        total++; if (halt !== 1'b1) begin bad++; $display("[TB] FAIL prog_halt: got %b expected 1", halt); end
        total++; if (pc !== 4'h5) begin bad++; $display("[TB] FAIL prog_pc: got %h expected 5", pc); end
        total++; if (carry !== 1'b1) begin bad++; $display("[TB] FAIL prog_carry: got %b expected 1", carry); end
        repeat (3) step(C_INC);
        step(C_OUT);
        total++; if (pc !== 4'h5) begin bad++; $display("[TB] FAIL halt_pc_frozen: got %h expected 5", pc); end
        total++; if (outs_seen.size() != 1) begin bad++; $display("[TB] FAIL halt_out_frozen: got %0d pulses expected 1", outs_seen.size()); end
        read_a(av);
        total++; if (av !== 8'h0C) begin bad++; $display("[TB] FAIL halt_bus_driven: got %h expected 0c", av); end
    endtask

    task automatic test_pc_wrap();
        logic [7:0] av;
        do_reset();
        repeat (17) step(C_INC);
        total++; if (pc !== 4'h1) begin bad++; $display("[TB] FAIL pc_wrap: got %h expected 1", pc); end
        repeat (10) step(C_IDLE);
        total++; if (pc !== 4'h1) begin bad++; $display("[TB] FAIL idle_pc: got %h expected 1", pc); end
        total++; if (out_reg !== 8'h00) begin bad++; $display("[TB] FAIL idle_out: got %h expected 00", out_reg); end
        total++; if (opcode !== 4'h0) begin bad++; $display("[TB] FAIL idle_opcode: got %h expected 0", opcode); end
        total++; if (bus !== 8'h00) begin bad++; $display("[TB] FAIL idle_bus: got %h expected 00", bus); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("[TB] FAIL idle_bus_err: got %b expected 0", bus_err); end
        total++; if (outs_seen.size() != 0) begin bad++; $display("[TB] FAIL idle_out_valid: got %0d pulses expected 0", outs_seen.size()); end
        read_a(av);
        total++; if (av !== 8'h00) begin bad++; $display("[TB] FAIL idle_a: got %h expected 00", av); end
    endtask

    task automatic test_alu();
        logic [7:0] av;
        prog_write(4'h0, 8'hF0); prog_write(4'h1, 8'h20);
        prog_write(4'h2, 8'h05); prog_write(4'h3, 8'h07);
        do_reset();
        step(C_MAR_PC); step(C_LOAD_A); step(C_INC); step(C_MAR_PC); step(C_LOAD_B);
        step(C_ADD);
        total++; if (carry !== 1'b1) begin bad++; $display("[TB] FAIL add_carry: got %b expected 1", carry); end
        read_a(av);
        total++; if (av !== 8'h10) begin bad++; $display("[TB] FAIL add_result: got %h expected 10", av); end
        step(C_INC); step(C_MAR_PC); step(C_LOAD_A); step(C_INC); step(C_MAR_PC); step(C_LOAD_B);
        step(C_SUB);
        total++; if (carry !== 1'b0) begin bad++; $display("[TB] FAIL sub_carry: got %b expected 0", carry); end
        read_a(av);
        total++; if (av !== 8'hFE) begin bad++; $display("[TB] FAIL sub_result: got %h expected fe", av); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("[TB] FAIL alu_bus_err: got %b expected 0", bus_err); end
    endtask

    task automatic test_contention();
        prog_write(4'h3, 8'h40);
        do_reset();
        repeat (3) step(C_INC);
        step(C_MAR_PC); step(C_LOAD_A);
        total++; if (bus_err !== 1'b0) begin bad++; $display("[TB] FAIL pre_contention: got %b expected 0", bus_err); end
        step(C_CONTEND);
        total++; if (bus !== 8'h43) begin bad++; $display("[TB] FAIL contention_bus: got %h expected 43", bus); end
        total++; if (bus_err !== 1'b1) begin bad++; $display("[TB] FAIL contention_flag: got %b expected 1", bus_err); end
        repeat (3) step(C_IDLE);
        total++; if (bus_err !== 1'b1) begin bad++; $display("[TB] FAIL contention_sticky: got %b expected 1", bus_err); end
        total++; if (bus !== 8'h00) begin bad++; $display("[TB] FAIL contention_idle_bus: got %h expected 00", bus); end
    endtask

    task automatic test_prog_mode();
        logic [7:0] av;
        do_reset();
        prog_en = 1'b1; prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'h77;
        step(C_INC_LDA);
        prog_en = 1'b0; prog_we = 1'b0;
        total++; if (pc !== 4'h0) begin bad++; $display("[TB] FAIL prog_mode_pc: got %h expected 0", pc); end
        read_a(av);
        total++; if (av !== 8'h00) begin bad++; $display("[TB] FAIL prog_mode_a: got %h expected 00", av); end
        step(C_MAR_PC); step(C_RAM_RD);
        total++; if (bus !== 8'h77) begin bad++; $display("[TB] FAIL prog_mode_ram: got %h expected 77", bus); end
        step(C_LOAD_A); step(C_LOAD_B); step(C_INC); step(C_OUT);
        reset = 1'b0; prog_en = 1'b1; prog_we = 1'b1; prog_addr = 4'h6; prog_data = 8'h5A;
        step(C_ADD);
        reset = 1'b1; prog_en = 1'b0; prog_we = 1'b0;
        total++; if (pc !== 4'h0) begin bad++; $display("[TB] FAIL midreset_pc: got %h expected 0", pc); end
        total++; if (out_reg !== 8'h00) begin bad++; $display("[TB] FAIL midreset_out: got %h expected 00", out_reg); end
        total++; if (carry !== 1'b0) begin bad++; $display("[TB] FAIL midreset_carry: got %b expected 0", carry); end
        read_a(av);
        total++; if (av !== 8'h00) begin bad++; $display("[TB] FAIL midreset_a: got %h expected 00", av); end
        step(C_SHOW_ALU);
        total++; if (bus !== 8'h00) begin bad++; $display("[TB] FAIL midreset_b: got %h expected 00", bus); end
        repeat (6) step(C_INC);
        step(C_MAR_PC); step(C_RAM_RD);
        total++; if (bus !== 8'h5A) begin bad++; $display("[TB] FAIL midreset_ram_write: got %h expected 5a", bus); end
    endtask

    // Random programs: LDA, 1..5 of ADD/SUB/OUT, OUT, HLT, checked by an instruction-level model
    task automatic test_random_programs();
        logic [7:0] pm [16];
        logic [7:0] expect_q[$];
        logic [7:0] acc;
        logic [8:0] wide;
        logic       carry_m;
        logic [3:0] op;
        logic [3:0] f;
        int         m;
        int         sel;
        for (int iter = 0; iter < 8; iter++) begin
            m = $urandom_range(1, 5);
            for (int k = 0; k < 16; k++) pm[k] = 8'($urandom);
            pm[0] = {OP_LDA, 4'($urandom_range(8, 15))};
            for (int k = 1; k <= m; k++) begin
                sel = $urandom_range(0, 2);
                op = (sel == 0) ? OP_ADD : (sel == 1) ? OP_SUB : OP_OUT;
                pm[k] = {op, 4'($urandom_range(8, 15))};
            end
            pm[m+1] = {OP_OUT, 4'h0};
            pm[m+2] = {OP_HLT, 4'h0};
            for (int k = 0; k < 16; k++) prog_write(4'(k), pm[k]);
            acc = 8'h00;
            carry_m = 1'b0;
            expect_q.delete();
            for (int k = 0; k <= m + 2; k++) begin
                op = pm[k][7:4];
                case (op)
                    OP_LDA: acc = pm[pm[k][3:0]];
                    OP_ADD: begin
                        wide = {1'b0, acc} + {1'b0, pm[pm[k][3:0]]};
                        carry_m = wide[8];
                        acc = wide[7:0];
                    end
                    OP_SUB: begin
                        carry_m = (acc >= pm[pm[k][3:0]]);
                        acc = acc - pm[pm[k][3:0]];
                    end
                    OP_OUT: expect_q.push_back(acc);
                    default: ;
                endcase
            end
            do_reset();
            for (int k = 0; k <= m + 2; k++) begin
                op = pm[k][7:4];
                run_instr(op, f);
                total++; if (f !== op) begin bad++; $display("[TB] FAIL rand_opcode it%0d pc%0d: got %h expected %h", iter, k, f, op); end
            end
            total++; if (outs_seen.size() != expect_q.size()) begin bad++; $display("[TB] FAIL rand_out_count it%0d: got %0d expected %0d", iter, outs_seen.size(), expect_q.size()); end
            else begin
                for (int k = 0; k < expect_q.size(); k++) begin
                    total++; if (outs_seen[k] !== expect_q[k]) begin bad++; $display("[TB] FAIL rand_out it%0d #%0d: got %h expected %h", iter, k, outs_seen[k], expect_q[k]); end
                end
            end
            total++; if (halt !== 1'b1) begin bad++; $display("[TB] FAIL rand_halt it%0d: got %b expected 1", iter, halt); end
            total++; if (pc !== 4'(m + 3)) begin bad++; $display("[TB] FAIL rand_pc it%0d: got %h expected %h", iter, pc, 4'(m + 3)); end
            total++; if (carry !== carry_m) begin bad++; $display("[TB] FAIL rand_carry it%0d: got %b expected %b", iter, carry, carry_m); end
        end
    endtask

    initial begin
        $display("[TB] starting sap1_datapath bench");
        test_reset();
        test_program();
        test_pc_wrap();
        test_alu();
        test_contention();
        test_prog_mode();
        test_random_programs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
